xadac_vec_dispatch: RTL and testbench
=====================================

# xadac_vec_dispatch

Vector dispatch stage of the XADAC coprocessor path. It accepts decoded, accepted instructions (`DecReqT`/`DecRspT` content), reads source vectors from the internal 32×128-bit vector register file (VRF), and enforces hazards through a per-register pending scoreboard and a per-ID in-flight table. It issues `ExeReqT`-shaped requests to the execute unit through a registered output stage. Execute responses (`ExeRspT`) return here for VRF writeback and scoreboard release.

## Interface
Parameters:
- `NoVs`, 3: vector source operands per instruction.
- `VecAddrWidth`, 5: VRF address width; 2**5 = 32 registers.
- `VecDataWidth`, 128: vector width in bits.
- `IdWidth`, 4: instruction ID width; 16 IDs.
- `InstrWidth`, 32: instruction word width.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `iss_valid_i` in 1: issue request valid.
- `iss_ready_o` out 1: issue accepted when valid & ready.
- `iss_id_i` in IdWidth: instruction ID.
- `iss_instr_i` in InstrWidth: instruction word.
- `iss_vs_addr_i` in NoVs×VecAddrWidth: source vector addresses.
- `iss_vs_read_i` in NoVs: source is used.
- `iss_vd_addr_i` in VecAddrWidth: destination vector.
- `iss_vd_clobber_i` in 1: instruction writes vd.
- `exe_valid_o` out 1: execute request valid.
- `exe_ready_i` in 1: execute unit accepts.
- `exe_id_o`, `exe_instr_o`, `exe_vs_addr_o`, `exe_vs_data_o` out: registered request fields; `exe_vs_data_o` is NoVs×VecDataWidth.
- `rsp_valid_i` in 1: execute response valid.
- `rsp_ready_o` out 1: constant 1.
- `rsp_id_i` in IdWidth: response ID.
- `rsp_vd_write_i` in 1: write VRF.
- `rsp_vd_addr_i` in VecAddrWidth: VRF write address.
- `rsp_vd_data_i` in VecDataWidth: VRF write data.
- `rsp_err_o` out 1: one-cycle pulse on a response whose ID is not in flight.

## Operation
- **State**
  - VRF: 32×128 flops.
  - `pend[31:0]`: register has an outstanding writer.
  - `busy[15:0]`: ID is in flight.
  - `vd_tab[id]`: stores `{vd_addr, vd_valid}` per ID.
  - Output stage: one register, `exe_valid_o` plus payload.
- **Hazard**, a stall:
  - `busy[iss_id_i]` is set; or
  - any `i` with `iss_vs_read_i[i]` and `pend[vs_addr[i]]` (RAW); or
  - `iss_vd_clobber_i` and `pend[vd_addr]` (WAW).
- **Issue acceptance:** `iss_ready_o = !hazard && (!exe_valid_o || exe_ready_i)`. This is combinational from the inputs and state.
- **On accept:**
  - Load the output register with id, instr, vs_addr and VRF read data.
  - Unused sources carry the VRF data at their address.
  - Set `busy[id]` and write `vd_tab[id] = {vd_addr, vd_clobber}`.
  - If `vd_clobber`, set `pend[vd_addr]`.
- **On response** (`rsp_valid_i`), when `busy[rsp_id_i]` is set:
  - Clear `busy[rsp_id_i]`.
  - If `vd_tab[rsp_id_i].vd_valid`, clear `pend[vd_tab.vd_addr]`. This uses the stored address, not `rsp_vd_addr_i`.
  - If `rsp_vd_write_i`, write `rsp_vd_data_i` to `VRF[rsp_vd_addr_i]`.
- **On response** when `busy[rsp_id_i]` is clear:
  - No state change, no VRF write.
  - Pulse `rsp_err_o` for one cycle.
- **Simultaneous set and clear** of the same `pend` bit or `busy` bit in one cycle: the set wins. The next owner's mark must survive.
- The output stage holds its payload stable while `exe_valid_o && !exe_ready_i`.

## Timing
- **Reset values:**
  - All outputs 0, except `rsp_ready_o` = 1.
  - VRF all zero; `pend` = 0; `busy` = 0; `vd_tab` = 0.
- **Issue latency:** accepted in cycle N, so `exe_valid_o` = 1 in cycle N+1. Back-to-back issue gives one request per cycle when `exe_ready_i` = 1.
- **Writeback visibility:** a VRF write in cycle N is readable by an issue in cycle N+1.
- **Scoreboard release:** `pend` and `busy` clear in N+1, so a dependent instruction issues in cycle N+1 at the earliest (no forwarding).
- **Reset mid-operation:** the in-flight request is dropped, `exe_valid_o` drops immediately (asynchronous), and all scoreboard state clears.

## Configuration
- **`XADAC_DISPATCH_FWD_EN` defined:**
  - A response in cycle N releases hazards combinationally in cycle N.
  - Its `rsp_vd_data_i` is forwarded to any source matching `rsp_vd_addr_i` (when `rsp_vd_write_i`).
  - A dependent instruction therefore issues in the same cycle as the response.
- **Undefined:** no forwarding. Hazards use registered state only, so there is a one-cycle bubble after each writeback.

## Test plan
- **Reset:** deassert `rst_ni`, then issue vs0 = v3 with `exe_ready_i` = 1 → `exe_valid_o` = 1 next cycle, `exe_vs_data_o[0]` = 0.
- **Writeback then read:** response id 2, `vd_write` = 1, v5 = 128'hA5..A5 (with id 2 previously in flight). Then issue with vs1 = v5 → `exe_vs_data_o[1]` = 128'hA5..A5.
- **RAW stall:**
  - Issue id 1 writing v7, then id 3 reading v7 → `iss_ready_o` = 0.
  - Response id 1 in cycle N → id 3 accepted in cycle N+1 (without macro) or cycle N (with macro, data forwarded).
- **ID reuse and backpressure:**
  - Issue id 4, then id 4 again before its response → stall.
  - Hold `exe_ready_i` = 0 for 3 cycles → payload stable, with only one additional accept possible.
- **Spurious response:** response with id 9 not in flight → `rsp_err_o` pulses once, VRF unchanged, `pend` unchanged.
- **Simultaneous events:** in the same cycle, the response for id 1 (vd v2) arrives and id 6 writing v2 is accepted (macro on) → `pend[2]` remains 1, and id 6's later response clears it.

Source files
------------

// File: rtl/xadac_vec_dispatch.sv
// XADAC vector dispatch: VRF read, pending/in-flight scoreboard, registered execute request stage.
// Define XADAC_DISPATCH_FWD_EN to release hazards and forward writeback data in the response cycle.

module xadac_vec_dispatch_src #(
    parameter int VecAddrWidth = 5,
    parameter int VecDataWidth = 128
) (
    input  logic [VecAddrWidth-1:0] addr_i,
    input  logic [VecDataWidth-1:0] rd_data_i,
    input  logic                    fwd_vld_i,
    input  logic [VecAddrWidth-1:0] fwd_addr_i,
    input  logic [VecDataWidth-1:0] fwd_data_i,
    output logic [VecDataWidth-1:0] data_o
);
    assign data_o = (fwd_vld_i && (fwd_addr_i == addr_i)) ? fwd_data_i : rd_data_i;
endmodule

module xadac_vec_dispatch #(
    parameter int NoVs         = 3,
    parameter int VecAddrWidth = 5,
    parameter int VecDataWidth = 128,
    parameter int IdWidth      = 4,
    parameter int InstrWidth   = 32
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         iss_valid_i,
    output logic                         iss_ready_o,
    input  logic [IdWidth-1:0]           iss_id_i,
    input  logic [InstrWidth-1:0]        iss_instr_i,
    input  logic [NoVs*VecAddrWidth-1:0] iss_vs_addr_i,
    input  logic [NoVs-1:0]              iss_vs_read_i,
    input  logic [VecAddrWidth-1:0]      iss_vd_addr_i,
    input  logic                         iss_vd_clobber_i,
    output logic                         exe_valid_o,
    input  logic                         exe_ready_i,
    output logic [IdWidth-1:0]           exe_id_o,
    output logic [InstrWidth-1:0]        exe_instr_o,
    output logic [NoVs*VecAddrWidth-1:0] exe_vs_addr_o,
    output logic [NoVs*VecDataWidth-1:0] exe_vs_data_o,
    input  logic                         rsp_valid_i,
    output logic                         rsp_ready_o,
    input  logic [IdWidth-1:0]           rsp_id_i,
    input  logic                         rsp_vd_write_i,
    input  logic [VecAddrWidth-1:0]      rsp_vd_addr_i,
    input  logic [VecDataWidth-1:0]      rsp_vd_data_i,
    output logic                         rsp_err_o
);
    localparam int NoRegs = 2**VecAddrWidth;
    localparam int NoIds  = 2**IdWidth;
`ifdef XADAC_DISPATCH_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    typedef struct packed {
        logic [IdWidth-1:0]                   id;
        logic [InstrWidth-1:0]                instr;
        logic [NoVs*VecAddrWidth-1:0]         vs_addr;
        logic [NoVs-1:0][VecDataWidth-1:0]    vs_data;
    } exe_req_t;

    typedef struct packed {
        logic [VecAddrWidth-1:0] vd_addr;
        logic                    vd_valid;
    } vd_ent_t;

    logic [NoRegs-1:0][VecDataWidth-1:0] vrf_q;
    logic [NoRegs-1:0]                   pend_q, pend_view, pend_clr, pend_set;
    logic [NoIds-1:0]                    busy_q, busy_view, busy_clr, busy_set;
    vd_ent_t [NoIds-1:0]                 vd_tab_q;
    vd_ent_t                             rsp_ent;
    exe_req_t                            exe_q;
    logic                                exe_valid_q;
    logic                                rsp_hit, hazard, iss_fire, fwd_vld;
    logic [NoVs-1:0][VecDataWidth-1:0]   src_data;

    assign rsp_hit = rsp_valid_i && busy_q[rsp_id_i];
    assign rsp_ent = vd_tab_q[rsp_id_i];
    assign fwd_vld = FwdEn && rsp_hit && rsp_vd_write_i;

    // Release uses the destination recorded at issue, not the response's write address.
    always_comb begin
        pend_clr = '0;
        busy_clr = '0;
        if (rsp_hit) begin
            busy_clr[rsp_id_i] = 1'b1;
            if (rsp_ent.vd_valid) pend_clr[rsp_ent.vd_addr] = 1'b1;
        end
        pend_view = FwdEn ? (pend_q & ~pend_clr) : pend_q;
        busy_view = FwdEn ? (busy_q & ~busy_clr) : busy_q;
    end

    always_comb begin
        hazard = busy_view[iss_id_i] || (iss_vd_clobber_i && pend_view[iss_vd_addr_i]);
        for (int i = 0; i < NoVs; i++) begin
            if (iss_vs_read_i[i] && pend_view[iss_vs_addr_i[i*VecAddrWidth +: VecAddrWidth]])
                hazard = 1'b1;
        end
    end

    assign iss_ready_o = rst_ni && !hazard && (!exe_valid_q || exe_ready_i);
    assign iss_fire    = iss_valid_i && iss_ready_o;

    always_comb begin
        pend_set = '0;
        busy_set = '0;
        if (iss_fire) begin
            busy_set[iss_id_i] = 1'b1;
            if (iss_vd_clobber_i) pend_set[iss_vd_addr_i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NoVs; g++) begin : g_src
        logic [VecAddrWidth-1:0] src_addr;
        assign src_addr = iss_vs_addr_i[g*VecAddrWidth +: VecAddrWidth];
        xadac_vec_dispatch_src #(
            .VecAddrWidth(VecAddrWidth),
            .VecDataWidth(VecDataWidth)
        ) u_src (
            .addr_i    (src_addr),
            .rd_data_i (vrf_q[src_addr]),
            .fwd_vld_i (fwd_vld),
            .fwd_addr_i(rsp_vd_addr_i),
            .fwd_data_i(rsp_vd_data_i),
            .data_o    (src_data[g])
        );
    end

    // Set after clear so a new owner's mark survives a same-cycle release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vrf_q    <= '0;
            pend_q   <= '0;
            busy_q   <= '0;
            vd_tab_q <= '0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | pend_set;
            busy_q <= (busy_q & ~busy_clr) | busy_set;
            if (iss_fire) vd_tab_q[iss_id_i] <= {iss_vd_addr_i, iss_vd_clobber_i};
            if (rsp_hit && rsp_vd_write_i) vrf_q[rsp_vd_addr_i] <= rsp_vd_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exe_valid_q <= 1'b0;
            exe_q       <= '0;
        end else if (iss_fire) begin
            exe_valid_q   <= 1'b1;
            exe_q.id      <= iss_id_i;
            exe_q.instr   <= iss_instr_i;
            exe_q.vs_addr <= iss_vs_addr_i;
            exe_q.vs_data <= src_data;
        end else if (exe_ready_i) begin
            exe_valid_q <= 1'b0;
        end
    end

    assign exe_valid_o   = exe_valid_q;
    assign exe_id_o      = exe_q.id;
    assign exe_instr_o   = exe_q.instr;
    assign exe_vs_addr_o = exe_q.vs_addr;
    assign exe_vs_data_o = exe_q.vs_data;
    assign rsp_ready_o   = 1'b1;
    assign rsp_err_o     = rsp_valid_i && !busy_q[rsp_id_i];

endmodule

// File: tb/tb_xadac_vec_dispatch.sv
// Randomized bench for xadac_vec_dispatch against an array-level scoreboard model.
// Define XADAC_DISPATCH_FWD_EN for both bench and RTL to test the forwarding build.

module tb_xadac_vec_dispatch;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         iss_valid, iss_ready, iss_vd_clobber;
    logic [3:0]   iss_id;
    logic [31:0]  iss_instr;
    logic [14:0]  iss_vs_addr;
    logic [2:0]   iss_vs_read;
    logic [4:0]   iss_vd_addr;
    logic         exe_valid, exe_ready;
    logic [3:0]   exe_id;
    logic [31:0]  exe_instr;
    logic [14:0]  exe_vs_addr;
    logic [383:0] exe_vs_data;
    logic         rsp_valid, rsp_ready, rsp_vd_write, rsp_err;
    logic [3:0]   rsp_id;
    logic [4:0]   rsp_vd_addr;
    logic [127:0] rsp_vd_data;

    always #5 clk = ~clk;

    xadac_vec_dispatch u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .iss_valid_i(iss_valid), .iss_ready_o(iss_ready), .iss_id_i(iss_id),
        .iss_instr_i(iss_instr), .iss_vs_addr_i(iss_vs_addr), .iss_vs_read_i(iss_vs_read),
        .iss_vd_addr_i(iss_vd_addr), .iss_vd_clobber_i(iss_vd_clobber),
        .exe_valid_o(exe_valid), .exe_ready_i(exe_ready), .exe_id_o(exe_id),
        .exe_instr_o(exe_instr), .exe_vs_addr_o(exe_vs_addr), .exe_vs_data_o(exe_vs_data),
        .rsp_valid_i(rsp_valid), .rsp_ready_o(rsp_ready), .rsp_id_i(rsp_id),
        .rsp_vd_write_i(rsp_vd_write), .rsp_vd_addr_i(rsp_vd_addr), .rsp_vd_data_i(rsp_vd_data),
        .rsp_err_o(rsp_err)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Architectural model: register file, scoreboard bits, destination table, output slot.
    logic [127:0] m_vrf [32];
    bit           m_pend[32];
    bit           m_busy[16];
    logic [4:0]   m_tvd [16];
    bit           m_tv  [16];
    bit           m_ev;
    logic [3:0]   m_eid;
    logic [31:0]  m_ein;
    logic [14:0]  m_ea;
    logic [383:0] m_ed;
    int           q[$];   // ids handed to execute, awaiting a response

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin m_vrf[i] = '0; m_pend[i] = 0; end
        for (int i = 0; i < 16; i++) begin m_busy[i] = 0; m_tvd[i] = '0; m_tv[i] = 0; end
        m_ev = 0; m_eid = '0; m_ein = '0; m_ea = '0; m_ed = '0;
        q.delete();
    endtask

    task automatic idle();
        iss_valid = 0; iss_id = '0; iss_instr = '0; iss_vs_addr = '0; iss_vs_read = '0;
        iss_vd_addr = '0; iss_vd_clobber = 0; exe_ready = 1;
        rsp_valid = 0; rsp_id = '0; rsp_vd_write = 0; rsp_vd_addr = '0; rsp_vd_data = '0;
    endtask

    task automatic iss(input int id, input int v0, input int v1, input int v2,
                       input int rd, input int vd, input bit clob);
        iss_valid = 1; iss_id = 4'(id); iss_instr = $urandom;
        iss_vs_addr = {5'(v2), 5'(v1), 5'(v0)}; iss_vs_read = 3'(rd);
        iss_vd_addr = 5'(vd); iss_vd_clobber = clob;
    endtask

    task automatic rsp(input int id, input bit wr, input int addr, input logic [127:0] d);
        rsp_valid = 1; rsp_id = 4'(id); rsp_vd_write = wr; rsp_vd_addr = 5'(addr); rsp_vd_data = d;
        for (int k = q.size() - 1; k >= 0; k--) if (q[k] == id) q.delete(k);
    endtask

    // Called at a falling edge with inputs set; returns at the next falling edge.
    task automatic do_cycle();
        bit           hit, haz, rdy, fire;
        bit           pv[32];
        bit           bv[16];
        logic [383:0] dat;
        logic [4:0]   a;
        #1;
        hit = rsp_valid && m_busy[rsp_id];
        pv = m_pend;
        bv = m_busy;
`ifdef XADAC_DISPATCH_FWD_EN
        if (hit) begin
            bv[rsp_id] = 0;
            if (m_tv[rsp_id]) pv[m_tvd[rsp_id]] = 0;
        end
`endif
        haz = bv[iss_id] || (iss_vd_clobber && pv[iss_vd_addr]);
        for (int i = 0; i < 3; i++) begin
            a = iss_vs_addr[i*5 +: 5];
            if (iss_vs_read[i] && pv[a]) haz = 1;
            dat[i*128 +: 128] = m_vrf[a];
`ifdef XADAC_DISPATCH_FWD_EN
            if (hit && rsp_vd_write && rsp_vd_addr == a) dat[i*128 +: 128] = rsp_vd_data;
`endif
        end
        rdy  = !haz && (!m_ev || exe_ready);
        fire = iss_valid && rdy;
        chk("iss_ready", iss_ready, rdy);
        chk("rsp_err", rsp_err, rsp_valid && !m_busy[rsp_id]);
        chk("rsp_ready", rsp_ready, 1);
        @(posedge clk);
        if (m_ev && exe_ready) q.push_back(int'(m_eid));
        if (fire) begin
            m_ev = 1; m_eid = iss_id; m_ein = iss_instr; m_ea = iss_vs_addr; m_ed = dat;
        end else if (exe_ready) m_ev = 0;
        if (hit) begin
            m_busy[rsp_id] = 0;
            if (m_tv[rsp_id]) m_pend[m_tvd[rsp_id]] = 0;
            if (rsp_vd_write) m_vrf[rsp_vd_addr] = rsp_vd_data;
        end
        if (fire) begin
            m_busy[iss_id] = 1; m_tvd[iss_id] = iss_vd_addr; m_tv[iss_id] = iss_vd_clobber;
            if (iss_vd_clobber) m_pend[iss_vd_addr] = 1;
        end
        #1;
        chk("exe_valid", exe_valid, m_ev);
        if (m_ev) begin
            chk("exe_id", exe_id, m_eid);
            chk("exe_instr", exe_instr, m_ein);
            chk("exe_vs_addr", exe_vs_addr, m_ea);
            chk("exe_vs_data", exe_vs_data, m_ed);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int id;
        idle();
        do_cycle();
        while (q.size() > 0) begin
            id = q[0];
            rsp(id, m_tv[id], int'(m_tvd[id]), {$urandom, $urandom, $urandom, $urandom});
            do_cycle();
            idle();
        end
        do_cycle();
    endtask

    task automatic check_reset_outputs();
        #1;
        chk("rst_exe_valid", exe_valid, 0);
        chk("rst_iss_ready", iss_ready, 0);
        chk("rst_exe_id", exe_id, 0);
        chk("rst_exe_data", exe_vs_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_ready", rsp_ready, 1);
    endtask

    initial begin
        logic [127:0] a5;
        int           r, id, k;
        a5 = {16{8'hA5}};
        idle();
        m_reset();
        rst_n = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1;

        // Fresh VRF reads as zero, one-cycle issue latency.
        iss(0, 3, 0, 0, 1, 0, 0); do_cycle();
        chk("reset_vs0", exe_vs_data[127:0], 0);
        drain();

        // Writeback then read.
        iss(2, 0, 0, 0, 0, 5, 1); do_cycle();
        idle(); do_cycle();
        rsp(2, 1, 5, a5); do_cycle();
        iss(5, 0, 5, 0, 2, 0, 0); do_cycle();
        chk("wb_vs1", exe_vs_data[255:128], a5);
        drain();

        // RAW stall, released by response.
        iss(1, 0, 0, 0, 0, 7, 1); do_cycle();
        iss(3, 7, 0, 0, 1, 0, 0); do_cycle();
        rsp(1, 1, 7, {4{32'h1234_5678}}); do_cycle();
        rsp_valid = 0; do_cycle();
        drain();

        // ID reuse, then backpressure with a single extra accept.
        iss(4, 1, 2, 3, 0, 0, 0); do_cycle();
        iss(4, 1, 2, 3, 0, 0, 0); do_cycle();
        drain();
        iss(8, 1, 2, 3, 7, 9, 0); exe_ready = 0;
        repeat (3) do_cycle();
        iss(10, 4, 4, 4, 7, 0, 0); exe_ready = 0; do_cycle();
        idle(); do_cycle();
        drain();

        // Spurious response leaves VRF and scoreboard alone.
        rsp(9, 1, 5, {4{32'hDEAD_BEEF}}); do_cycle();
        idle(); do_cycle();
        iss(11, 5, 0, 0, 1, 0, 0); do_cycle();
        chk("spur_vrf", exe_vs_data[127:0], a5);
        drain();

        // Release and re-mark of the same register in one cycle.
        iss(1, 0, 0, 0, 0, 2, 1); do_cycle();
        idle(); do_cycle();
        rsp(1, 1, 2, {4{32'h0BAD_F00D}}); iss(6, 0, 0, 0, 0, 2, 1); do_cycle();
        rsp_valid = 0; do_cycle();
        idle(); do_cycle();
        iss(12, 2, 0, 0, 1, 0, 0); do_cycle();
        rsp(6, 1, 2, {4{32'h600D_CAFE}}); do_cycle();
        rsp_valid = 0; do_cycle();
        drain();

        // Randomized traffic over a small register window to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            idle();
            iss_valid      = ($urandom_range(0, 9) < 7);
            iss_id         = 4'($urandom_range(0, 15));
            iss_instr      = $urandom;
            iss_vs_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            iss_vs_read    = 3'($urandom_range(0, 7));
            iss_vd_addr    = 5'($urandom_range(0, 7));
            iss_vd_clobber = ($urandom_range(0, 3) != 0);
            exe_ready      = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 4 && q.size() > 0) begin
                k = $urandom_range(0, q.size() - 1);
                id = q[k];
                rsp(id, m_tv[id] || (r == 0), m_tv[id] ? int'(m_tvd[id]) : $urandom_range(0, 7),
                    {$urandom, $urandom, $urandom, $urandom});
            end else if (r == 9) begin
                id = $urandom_range(0, 15);
                if (!m_busy[id]) rsp(id, 1, $urandom_range(0, 7), {$urandom, $urandom, $urandom, $urandom});
            end
            do_cycle();
        end

        // Asynchronous reset in the middle of traffic.
        iss(13, 1, 2, 3, 0, 0, 0); exe_ready = 0; #1;
        rst_n = 0;
        #1;
        chk("rst_async_valid", exe_valid, 0);
        idle();
        m_reset();
        @(negedge clk);
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1;
        iss(0, 3, 0, 0, 1, 0, 0); do_cycle();
        chk("rst_mid_vs0", exe_vs_data[127:0], 0);
        idle(); do_cycle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
